// File: rtl/sign_mag_operand_loader.sv
// Two's-complement to sign-magnitude operand loader.
// Gathers words into an A/B pair and holds the pair under a valid/ready handshake.
module sign_mag_operand_loader #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic         ops_valid,
  input  logic         ops_ready,
  output logic         sat_a,
  output logic         sat_b
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [N-2:0] MAG_ONE = 1;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         sat_a_q, sat_a_d;
  logic         sat_b_q, sat_b_d;

  logic [N-1:0] conv_word;
  logic         conv_sat;
  logic         din_fire;
  logic         ops_fire;

  // The most negative word has no positive counterpart, so it clips to max magnitude.
  always_comb begin
    conv_word = {1'b0, din[N-2:0]};
    conv_sat  = 1'b0;
    if (din[N-1]) begin
      if (din[N-2:0] == '0) begin
        conv_word = '1;
        conv_sat  = 1'b1;
      end else begin
        conv_word = {1'b1, ~din[N-2:0] + MAG_ONE};
      end
    end
  end

  assign ops_valid = (state_q == S_OUT);
  assign din_ready = (state_q != S_OUT) | ops_ready;
  assign din_fire  = din_valid & din_ready;
  assign ops_fire  = ops_valid & ops_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_a_d = sat_a_q;
    sat_b_d = sat_b_q;
    case (state_q)
      S_A: begin
        if (din_fire) begin
          a_d     = conv_word;
          sat_a_d = conv_sat;
          state_d = S_B;
        end
      end
      S_B: begin
        if (din_fire) begin
          b_d     = conv_word;
          sat_b_d = conv_sat;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (ops_fire) begin
          if (din_fire) begin
            a_d     = conv_word;
            sat_a_d = conv_sat;
            state_d = S_B;
          end else begin
            state_d = S_A;
          end
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      sat_a_q <= 1'b0;
      sat_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_a_q <= sat_a_d;
      sat_b_q <= sat_b_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign sat_a = sat_a_q;
  assign sat_b = sat_b_q;

endmodule

// File: tb/tb_sign_mag_operand_loader.sv
// Directed-vector bench for sign_mag_operand_loader (N=4).
// Inputs change 1ns after each rising edge; outputs are checked in that same window.
module tb_sign_mag_operand_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       ops_valid;
  logic       ops_ready;
  logic       sat_a;
  logic       sat_b;

  int errors = 0;
  int checks = 0;

  sign_mag_operand_loader #(.N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .A         (A),
    .B         (B),
    .ops_valid (ops_valid),
    .ops_ready (ops_ready),
    .sat_a     (sat_a),
    .sat_b     (sat_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; din = 4'h0; din_valid = 1'b0; ops_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    checks++; if (A !== 4'b0000) begin errors++; $display("FAIL reset_A got=%b exp=0000", A); end
    checks++; if (B !== 4'b0000) begin errors++; $display("FAIL reset_B got=%b exp=0000", B); end
    checks++; if ({sat_a, sat_b} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {sat_a, sat_b}); end
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL reset_ops_valid got=%b exp=0", ops_valid); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic_pair();
    din = 4'b0011; din_valid = 1'b1; ops_ready = 1'b0;
    step();
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after_A got=%b exp=0", ops_valid); end
    checks++; if (A !== 4'b0011) begin errors++; $display("FAIL basic_A_early got=%b exp=0011", A); end
    din = 4'b1110;
    step();
    din_valid = 1'b0;
    checks++; if (ops_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ops_valid); end
    checks++; if (A !== 4'b0011) begin errors++; $display("FAIL basic_A got=%b exp=0011", A); end
    checks++; if (B !== 4'b1010) begin errors++; $display("FAIL basic_B got=%b exp=1010", B); end
    checks++; if ({sat_a, sat_b} !== 2'b00) begin errors++; $display("FAIL basic_flags got=%b exp=00", {sat_a, sat_b}); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_din_ready got=%b exp=0", din_ready); end
    $display("test_basic_pair: A=%b B=%b", A, B);
  endtask

  task automatic test_saturation();
    ops_ready = 1'b1; din_valid = 1'b0;
    step();
    ops_ready = 1'b0;
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL sat_release got=%b exp=0", ops_valid); end
    din = 4'b1000; din_valid = 1'b1;
    step();
    din = 4'b0111;
    step();
    din_valid = 1'b0;
    checks++; if (A !== 4'b1111) begin errors++; $display("FAIL sat_A got=%b exp=1111", A); end
    checks++; if (sat_a !== 1'b1) begin errors++; $display("FAIL sat_a got=%b exp=1", sat_a); end
    checks++; if (B !== 4'b0111) begin errors++; $display("FAIL sat_B got=%b exp=0111", B); end
    checks++; if (sat_b !== 1'b0) begin errors++; $display("FAIL sat_b got=%b exp=0", sat_b); end
    checks++; if (ops_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got=%b exp=1", ops_valid); end
    $display("test_saturation: A=%b sat_a=%b B=%b sat_b=%b", A, sat_a, B, sat_b);
  endtask

  task automatic test_hold();
    din = 4'b0101; din_valid = 1'b1; ops_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL hold_din_ready[%0d] got=%b exp=0", i, din_ready); end
      step();
      checks++; if ({A, B, sat_a, sat_b} !== {4'b1111, 4'b0111, 2'b10}) begin
        errors++; $display("FAIL hold_regs[%0d] got=%b_%b_%b%b exp=1111_0111_10", i, A, B, sat_a, sat_b);
      end
      checks++; if (ops_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, ops_valid); end
    end
    din_valid = 1'b0;
    $display("test_hold done");
  endtask

  task automatic test_back_to_back();
    ops_ready = 1'b1; din_valid = 1'b1; din = 4'b1111;
    #1;
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_din_ready got=%b exp=1", din_ready); end
    step();
    ops_ready = 1'b0;
    checks++; if (A !== 4'b1001) begin errors++; $display("FAIL b2b_A got=%b exp=1001", A); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL b2b_sat_a got=%b exp=0", sat_a); end
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_low got=%b exp=0", ops_valid); end
    din = 4'b0001;
    step();
    din_valid = 1'b0;
    checks++; if (B !== 4'b0001) begin errors++; $display("FAIL b2b_B got=%b exp=0001", B); end
    checks++; if (A !== 4'b1001) begin errors++; $display("FAIL b2b_A_keep got=%b exp=1001", A); end
    checks++; if (ops_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_high got=%b exp=1", ops_valid); end
    $display("test_back_to_back: A=%b B=%b", A, B);
  endtask

  task automatic test_reset_midpair();
    // Load a doubly saturated pair so the reset has non-zero flags to clear.
    ops_ready = 1'b1; din_valid = 1'b1; din = 4'b1000;
    step();
    ops_ready = 1'b0;
    step();
    checks++; if ({sat_a, sat_b} !== 2'b11) begin errors++; $display("FAIL mid_flags_set got=%b exp=11", {sat_a, sat_b}); end
    ops_ready = 1'b1; din = 4'b0010;
    step();
    ops_ready = 1'b0; din_valid = 1'b0;
    checks++; if (A !== 4'b0010) begin errors++; $display("FAIL mid_A got=%b exp=0010", A); end
    checks++; if (sat_b !== 1'b1) begin errors++; $display("FAIL mid_sat_b_kept got=%b exp=1", sat_b); end
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL mid_in_S_B got=%b exp=0", ops_valid); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++; if ({A, B} !== 8'h00) begin errors++; $display("FAIL mid_reset_AB got=%b_%b exp=0000_0000", A, B); end
    checks++; if ({sat_a, sat_b} !== 2'b00) begin errors++; $display("FAIL mid_reset_flags got=%b exp=00", {sat_a, sat_b}); end
    din = 4'b0100; din_valid = 1'b1;
    step();
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_first got=%b exp=0", ops_valid); end
    din = 4'b1101;
    step();
    din_valid = 1'b0;
    checks++; if ({A, B} !== {4'b0100, 4'b1011}) begin errors++; $display("FAIL mid_fresh_pair got=%b_%b exp=0100_1011", A, B); end
    checks++; if (ops_valid !== 1'b1) begin errors++; $display("FAIL mid_fresh_valid got=%b exp=1", ops_valid); end
    $display("test_reset_midpair: A=%b B=%b", A, B);
  endtask

  task automatic test_stream();
    logic [3:0] words [8];
    logic [3:0] exp_w [8];
    logic       exp_s [8];
    int         pairs;
    words = '{4'h5, 4'hA, 4'h8, 4'h0, 4'hF, 4'h7, 4'h3, 4'hC};
    exp_w = '{4'b0101, 4'b1110, 4'b1111, 4'b0000, 4'b1001, 4'b0111, 4'b0011, 4'b1100};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pairs = 0;
    ops_ready = 1'b1; din_valid = 1'b0;
    step();
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = words[i];
      #1;
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL stream_din_ready[%0d] got=%b exp=1", i, din_ready); end
      step();
      checks++; if (ops_valid !== 1'(i % 2)) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=%0d", i, ops_valid, i % 2); end
      if (i % 2 == 1) begin
        pairs++;
        checks++; if ({A, sat_a, B, sat_b} !== {exp_w[i-1], exp_s[i-1], exp_w[i], exp_s[i]}) begin
          errors++;
          $display("FAIL stream_pair[%0d] got=A%b/%b B%b/%b exp=A%b/%b B%b/%b", pairs,
                   A, sat_a, B, sat_b, exp_w[i-1], exp_s[i-1], exp_w[i], exp_s[i]);
        end
        $display("stream pair %0d: A=%b sat_a=%b B=%b sat_b=%b", pairs, A, sat_a, B, sat_b);
      end
    end
    din_valid = 1'b0;
    step();
    checks++; if (ops_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", ops_valid); end
    checks++; if (pairs !== 4) begin errors++; $display("FAIL stream_pairs got=%0d exp=4", pairs); end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_saturation();
    test_hold();
    test_back_to_back();
    test_reset_midpair();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
